fib_seq_engine: RTL
===================

# fib_seq_engine

Self-sequenced, parametrised Fibonacci/Lucas sequence generator. It replaces externally driven enable/select sequencing with an internal FSM and a start/done handshake. It streams every term up to index n and holds the final term and an overflow flag until the next run. It sits in the sequence-datapath area as a drop-in compute engine for a host controller or testbench sequencer.

## Interface
- WIDTH, 16, data width of terms and result (≥ 4)
- N_WIDTH, 8, width of the target index n and of the index output

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clock clock
- start  in  1  request a run; sampled only in IDLE
- abort  in  1  cancel a run in progress; sampled only in RUN
- mode  in  1  0 = Fibonacci (seeds 0, 1); 1 = Lucas (seeds 2, 1); captured with start
- n  in  N_WIDTH  target index; captured with start
- busy  out  1  high in RUN and DONE
- valid  out  1  high in each RUN cycle; term/index are valid
- term  out  WIDTH  current term, modulo 2^WIDTH
- index  out  N_WIDTH  index of current term
- done  out  1  one-cycle pulse when result and overflow update
- result  out  WIDTH  term n of the last completed run; held until the next completion
- overflow  out  1  term n of the last completed run wrapped; held with result

## Operation
- States: IDLE, RUN, DONE.
- Internal registers: a, b (WIDTH), a_ovf, b_ovf, k (N_WIDTH), n_q, mode_q.
- IDLE, start=1: capture n_q=n and mode_q=mode. Load a=seed0 and b=seed1, with seed0 = 0 or 2 and seed1 = 1 per mode. Clear a_ovf, b_ovf, and k. Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, abort=1: go to IDLE. result, overflow, and done are untouched. No valid is emitted that cycle.
- RUN, abort=0: valid=1, term=a, index=k.
  - If k==n_q: result<=a, overflow<=a_ovf, go to DONE.
  - Otherwise: a<=b, a_ovf<=b_ovf, b<=a+b truncated to WIDTH, b_ovf<=a_ovf|b_ovf|carry_out(a+b), k<=k+1.
- DONE: done=1 for this cycle only, then go to IDLE.
- start is ignored outside IDLE. abort is ignored outside RUN. start and abort asserted together in IDLE: start wins.
- Arithmetic is unsigned and wraps modulo 2^WIDTH. The overflow flag is sticky along the sequence, so any wrapped ancestor marks every later term.
- n=0 is legal: one valid cycle with term=seed0, result=seed0.
- n_q is never reloaded mid-run, so a changing n input has no effect during a run.

## Timing
- Reset value of every output is 0: busy, valid, term, index, done, result, overflow. FSM resets to IDLE and internal registers clear. Reset overrides start and abort and takes effect mid-run with no done pulse.
- valid, term, index, busy, and done are registered or state-decoded. They are glitch-free and have no combinational path from the inputs.
- With start sampled at edge E0:
  - RUN occupies the n+1 cycles following E0, with valid high on every one.
  - index = 0..n in consecutive cycles.
  - done is high in cycle n+2 after E0, coincident with the first cycle in which result and overflow show the new values.
  - busy falls with the next edge, returning to IDLE.
- Earliest next start is sampled in the first IDLE cycle after DONE. The back-to-back period is n+3 cycles.
- Abort latency: abort sampled at edge Ea leaves valid low and busy low from the cycle after Ea.

## Test plan
- Fibonacci, WIDTH=16, n=10, start for 1 cycle -> 11 valid cycles with term 0,1,1,2,3,5,8,13,21,34,55 and index 0..10. done at cycle 12 after start, result=55, overflow=0.
- Lucas, mode=1, n=5 -> terms 2,1,3,4,7,11. result=11, done at cycle 7. A following Fibonacci run with n=0 -> a single term 0, result=0, done 2 cycles after start.
- WIDTH=8:
  - n=13 -> result=233, overflow=0.
  - n=14 -> result=121 (377 mod 256), overflow=1.
  - n=20 -> overflow=1.
- During a run with n=10, pulse start with n=3 mid-run -> ignored. Run completes with result=55, then busy=0.
- Pulse abort at index 4 of an n=10 run -> valid and busy low next cycle, no done pulse, result still holds the previous value. A new start then runs normally.
- Assert reset at index 6 of a run -> all outputs 0 next cycle and FSM in IDLE. A subsequent start with n=7 -> result=13.

Source files
------------

// File: rtl/fib_seq_engine.sv
// Self-sequenced Fibonacci/Lucas term generator with a start/done handshake.
// Streams terms 0..n, then holds term n and its wrap flag until the next run.
module fib_seq_engine #(
    parameter int WIDTH   = 16,
    parameter int N_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [N_WIDTH-1:0] n,
    output logic               busy,
    output logic               valid,
    output logic [WIDTH-1:0]   term,
    output logic [N_WIDTH-1:0] index,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] FIB_SEED0 = '0;
    localparam logic [WIDTH-1:0] LUC_SEED0 = WIDTH'(2);
    localparam logic [WIDTH-1:0] SEED1     = WIDTH'(1);

    state_t             state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               a_ovf;
    logic               b_ovf;
    logic [N_WIDTH-1:0] k;
    logic [N_WIDTH-1:0] n_q;
    logic [WIDTH:0]     sum;

    // The extra top bit of the sum is the carry that marks a wrapped term.
    assign sum = {1'b0, a} + {1'b0, b};

    // a and k are registers, so the streamed term and index are glitch-free.
    assign term  = a;
    assign index = k;

    // NOTE: every register here is assigned with <= so all updates in one edge
    // see the same pre-edge values (a<=b and b<=a+b must not race).
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            a_ovf    <= 1'b0;
            b_ovf    <= 1'b0;
            k        <= '0;
            n_q      <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n_q   <= n;
                        a     <= mode ? LUC_SEED0 : FIB_SEED0;
                        b     <= SEED1;
                        a_ovf <= 1'b0;
                        b_ovf <= 1'b0;
                        k     <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                        valid <= 1'b1;
                    end
                end

                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                    end else if (k == n_q) begin
                        result   <= a;
                        overflow <= a_ovf;
                        state    <= DONE;
                        valid    <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        a     <= b;
                        a_ovf <= b_ovf;
                        b     <= sum[WIDTH-1:0];
                        // Sticky: any wrapped ancestor taints every later term.
                        b_ovf <= a_ovf | b_ovf | sum[WIDTH];
                        k     <= k + N_WIDTH'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
